// File: rtl/uart_tx_frame_sched_if.sv
// uart_tx_frame_sched_if
//   Bundles the frame-request, buffer-read and UART-transmit signals of the
//   UART frame scheduler so the top level connects one interface instance.
//
//   req      [1:0] single-cycle frame requests (bit0 time report, bit1 status)
//   len0/len1 [7:0] frame lengths of source 0 / source 1, sampled at grant
//   rd_sel        source whose buffer is addressed
//   rd_addr  [7:0] byte index into the selected buffer
//   rd_data  [7:0] byte at rd_sel/rd_addr (combinational from the source)
//   tx_data  [7:0] byte to the UART transmitter (ip_data)
//   tx_flag       one-cycle strobe to the UART transmitter (ip_flag)
//   grant    [1:0] one-hot active source, 0 when idle
//   done     [1:0] one-cycle completion pulse per source
//   busy          scheduler is not idle
//
//   master: the sources / UART side.  slave: the scheduler.
interface uart_tx_frame_sched_if;
  logic [1:0] req;
  logic [7:0] len0;
  logic [7:0] len1;
  logic       rd_sel;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;

  modport master (
    output req, len0, len1, rd_data,
    input  rd_sel, rd_addr, tx_data, tx_flag, grant, done, busy
  );

  modport slave (
    input  req, len0, len1, rd_data,
    output rd_sel, rd_addr, tx_data, tx_flag, grant, done, busy
  );
endinterface

// File: rtl/uart_tx_frame_sched.sv
// uart_tx_frame_sched
//   Shares one UART transmitter between the IRIG-B time-report string
//   (source 0) and the status/echo message (source 1). Requests are latched
//   (one pending frame per source), arbitrated round-robin, and the granted
//   frame is streamed byte-by-byte from the source buffer with tx_flag
//   strobes exactly BYTE_GAP cycles apart.
//
//   Ports: clk, rst_n (asynchronous, active-low) and bus
//   (uart_tx_frame_sched_if.slave) carrying req/len0/len1/rd_data in and
//   rd_sel/rd_addr/tx_data/tx_flag/grant/done/busy out.
//
//   Parameters: BYTE_GAP (cycles between tx_flag pulses, >= one UART byte
//   time, >= 2), MAX_LEN (frame length clamp).
//
//   Optional build macro TX_CRLF_EN: appends 0x0D 0x0A after every frame.
module uart_tx_frame_sched #(
  parameter int BYTE_GAP = 60000,
  parameter int MAX_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_frame_sched_if.slave bus
);

  localparam int                 CNT_W     = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;
  // GAP lasts BYTE_GAP-1 cycles; with the LOAD cycle that spaces strobes BYTE_GAP apart.
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(BYTE_GAP - 2);
  localparam logic [7:0]         MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_GAP, S_TAIL, S_DONE
  } state_t;

  state_t           state_q,      state_d;
  logic [1:0]       pending_q,    pending_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       grant_q,      grant_d;
  logic             rd_sel_q,     rd_sel_d;
  logic [7:0]       rd_addr_q,    rd_addr_d;
  logic [7:0]       len_q,        len_d;
  logic [CNT_W-1:0] gap_cnt_q,    gap_cnt_d;
  logic [7:0]       tx_data_q,    tx_data_d;
  logic             tx_flag_q,    tx_flag_d;
  logic [1:0]       done_q,       done_d;
  logic             busy_q,       busy_d;
`ifdef TX_CRLF_EN
  // 0: buffer bytes, 1: CR slot, 2: LF slot
  logic [1:0]       term_q,       term_d;
`endif

  logic       winner;
  logic [7:0] len_sel;
  logic [7:0] len_clamp;
  logic       last_byte;

  // On a tie the source that did not go last wins.
  assign winner    = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
  assign len_sel   = winner ? bus.len1 : bus.len0;
  assign len_clamp = (len_sel > MAX_LEN_B) ? MAX_LEN_B : len_sel;
  assign last_byte = (rd_addr_q == len_q - 8'd1);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | bus.req;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rd_sel_d     = rd_sel_q;
    rd_addr_d    = rd_addr_q;
    len_d        = len_q;
    gap_cnt_d    = gap_cnt_q;
    tx_data_d    = tx_data_q;
    tx_flag_d    = 1'b0;
    done_d       = 2'b00;
`ifdef TX_CRLF_EN
    term_d       = term_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pending_q != 2'b00) state_d = S_ARB;
      end

      S_ARB: begin
        grant_d   = winner ? 2'b10 : 2'b01;
        rd_sel_d  = winner;
        rd_addr_d = 8'd0;
        len_d     = len_clamp;
`ifdef TX_CRLF_EN
        // An empty frame still carries its CR LF terminator.
        term_d    = (len_clamp == 8'd0) ? 2'd1 : 2'd0;
        state_d   = S_LOAD;
`else
        state_d   = (len_clamp == 8'd0) ? S_DONE : S_LOAD;
`endif
      end

      S_LOAD: begin
`ifdef TX_CRLF_EN
        case (term_q)
          2'd1:    tx_data_d = 8'h0D;
          2'd2:    tx_data_d = 8'h0A;
          default: tx_data_d = bus.rd_data;
        endcase
`else
        tx_data_d = bus.rd_data;
`endif
        tx_flag_d = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
`ifdef TX_CRLF_EN
          if (term_q == 2'd2) begin
            state_d = S_TAIL;
          end else if (term_q == 2'd1) begin
            term_d  = 2'd2;
            state_d = S_LOAD;
          end else if (last_byte) begin
            // rd_addr stays on the last buffer byte while CR LF go out.
            term_d  = 2'd1;
            state_d = S_LOAD;
          end else begin
            rd_addr_d = rd_addr_q + 8'd1;
            state_d   = S_LOAD;
          end
`else
          if (last_byte) begin
            state_d = S_TAIL;
          end else begin
            rd_addr_d = rd_addr_q + 8'd1;
            state_d   = S_LOAD;
          end
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      // Occupies the slot where the next LOAD would have been, so DONE
      // falls one full BYTE_GAP after the final strobe.
      S_TAIL: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d       = grant_q;
        last_grant_d = rd_sel_q;
        grant_d      = 2'b00;
        // A request landing in this very cycle re-arms the source.
        pending_d    = (pending_q & ~grant_q) | bus.req;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= 2'b00;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      rd_sel_q     <= 1'b0;
      rd_addr_q    <= 8'd0;
      len_q        <= 8'd0;
      gap_cnt_q    <= '0;
      tx_data_q    <= 8'd0;
      tx_flag_q    <= 1'b0;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
`ifdef TX_CRLF_EN
      term_q       <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rd_sel_q     <= rd_sel_d;
      rd_addr_q    <= rd_addr_d;
      len_q        <= len_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_flag_q    <= tx_flag_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef TX_CRLF_EN
      term_q       <= term_d;
`endif
    end
  end

  assign bus.rd_sel  = rd_sel_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_flag = tx_flag_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// tb_uart_tx_frame_sched
//   Directed bench for uart_tx_frame_sched with BYTE_GAP=16, MAX_LEN=32.
//   Source buffers: source 0 byte i = 0x41+i, source 1 byte i = 0x30+i.
//   Build with TX_CRLF_EN defined to exercise the CR LF terminator.
module tb_uart_tx_frame_sched;
  localparam int GAP = 16;
`ifdef TX_CRLF_EN
  localparam int XTRA = 2;
`else
  localparam int XTRA = 0;
`endif

  typedef struct {
    logic [1:0] req;
    logic [7:0] l0;
    logic [7:0] l1;
    int         bc;     // buffer bytes sent after clamping
    logic [7:0] first;  // first byte without terminator
    logic [7:0] last;   // last buffer byte
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  vec_t vecs [8];

  always #5 clk = ~clk;

  uart_tx_frame_sched_if bus ();

  uart_tx_frame_sched #(.BYTE_GAP(GAP), .MAX_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rd_data = bus.rd_sel ? mem1[bus.rd_addr] : mem0[bus.rd_addr];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int frame_lat(input int n);
    return (n == 0) ? 3 : GAP * n + 4;
  endfunction

  function automatic logic [7:0] exp_byte(input logic src, input int j, input int bc);
    if (j < bc) return src ? mem1[8'(j)] : mem0[8'(j)];
    return (j == bc) ? 8'h0D : 8'h0A;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    logic       src;
    logic       seen;
    int         n, lat, nflag, last_k;
    logic [7:0] first_b, last_b, ef, el;
    src = v.req[1];
    n = v.bc + XTRA;
    lat = frame_lat(n);
    nflag = 0; last_k = 0; seen = 1'b0; first_b = 8'd0; last_b = 8'd0;
    ef = (XTRA > 0 && v.bc == 0) ? 8'h0D : v.first;
    el = (XTRA > 0) ? 8'h0A : v.last;
    @(negedge clk);
    bus.len0 = v.l0; bus.len1 = v.l1; bus.req = v.req;
    @(negedge clk);
    bus.req = 2'b00;
    for (int k = 1; k <= lat + 2 * GAP; k++) begin
      @(negedge clk);
      if (bus.tx_flag) begin
        if (nflag == 0) begin
          check({tag, ".first_flag_cycle"}, k, 3);
          check({tag, ".grant"}, 32'(bus.grant), 32'(v.req));
          check({tag, ".busy"}, 32'(bus.busy), 1);
          first_b = bus.tx_data;
          bus.len0 = 8'd7; bus.len1 = 8'd7;
        end else begin
          check({tag, ".flag_spacing"}, k - last_k, GAP);
        end
        check({tag, ".byte"}, 32'(bus.tx_data), 32'(exp_byte(src, nflag, v.bc)));
        check({tag, ".rd_addr"}, 32'(bus.rd_addr),
              (nflag < v.bc) ? nflag : ((v.bc == 0) ? 0 : v.bc - 1));
        last_b = bus.tx_data;
        last_k = k;
        nflag++;
      end
      if (bus.done != 2'b00) begin
        check({tag, ".done_src"}, 32'(bus.done), 32'(v.req));
        check({tag, ".done_cycle"}, k, lat);
        check({tag, ".grant_cleared"}, 32'(bus.grant), 0);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s.done_timeout: no done pulse within %0d cycles", tag, lat + 2 * GAP);
    end
    check({tag, ".flag_count"}, nflag, n);
    if (n > 0) begin
      check({tag, ".first_byte"}, 32'(first_b), 32'(ef));
      check({tag, ".last_byte"}, 32'(last_b), 32'(el));
    end
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(bus.done), 0);
    check({tag, ".idle"}, 32'(bus.busy), 0);
  endtask

  task automatic run_pair(input logic first_src, input string tag);
    int         lat, nd;
    logic [1:0] g1, g2;
    g1 = first_src ? 2'b10 : 2'b01;
    g2 = first_src ? 2'b01 : 2'b10;
    lat = frame_lat(2 + XTRA);
    nd = 0;
    @(negedge clk);
    bus.len0 = 8'd2; bus.len1 = 8'd2; bus.req = 2'b11;
    @(negedge clk);
    bus.req = 2'b00;
    for (int k = 1; k <= 2 * lat + 2 * GAP && nd < 2; k++) begin
      @(negedge clk);
      if (k == 3) check({tag, ".first_grant"}, 32'(bus.grant), 32'(g1));
      if (bus.done != 2'b00) begin
        if (nd == 0) begin
          check({tag, ".first_done_src"}, 32'(bus.done), 32'(g1));
          check({tag, ".first_done_cycle"}, k, lat);
        end else begin
          check({tag, ".second_done_src"}, 32'(bus.done), 32'(g2));
          check({tag, ".second_done_cycle"}, k, 2 * lat);
        end
        nd++;
      end
    end
    check({tag, ".frames"}, nd, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat, nd, nf;
    logic hit;

    bus.req = 2'b00; bus.len0 = 8'd0; bus.len1 = 8'd0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h41 + 8'(i);
      mem1[i] = 8'h30 + 8'(i);
    end
    vecs[0] = '{2'b01, 8'd3,   8'd0,   3,  8'h41, 8'h43};
    vecs[1] = '{2'b10, 8'd9,   8'd0,   0,  8'h00, 8'h00};
    vecs[2] = '{2'b01, 8'd40,  8'd7,   32, 8'h41, 8'h60};
    vecs[3] = '{2'b10, 8'd0,   8'd5,   5,  8'h30, 8'h34};
    vecs[4] = '{2'b01, 8'd1,   8'd3,   1,  8'h41, 8'h41};
    vecs[5] = '{2'b10, 8'd2,   8'd255, 32, 8'h30, 8'h4F};
    vecs[6] = '{2'b01, 8'd32,  8'd0,   32, 8'h41, 8'h60};
    vecs[7] = '{2'b10, 8'd0,   8'd33,  32, 8'h30, 8'h4F};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.tx_data", 32'(bus.tx_data), 0);
    check("reset.tx_flag", 32'(bus.tx_flag), 0);
    check("reset.grant",   32'(bus.grant), 0);
    check("reset.done",    32'(bus.done), 0);
    check("reset.busy",    32'(bus.busy), 0);
    check("reset.rd_sel",  32'(bus.rd_sel), 0);
    check("reset.rd_addr", 32'(bus.rd_addr), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // vec7 was source 1, so a tie now goes to source 0.
    run_pair(1'b0, "pair_a");
    run_frame(vecs[0], "solo0");
    run_pair(1'b1, "pair_b");

    // Re-request in the DONE cycle queues a second frame; later pulses are absorbed.
    lat = frame_lat(1 + XTRA);
    nd = 0;
    @(negedge clk);
    bus.len0 = 8'd1; bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    for (int k = 1; k <= 3 * lat + GAP; k++) begin
      @(negedge clk);
      bus.req = (k == lat - 1 || k == lat + 5 || k == lat + 12) ? 2'b01 : 2'b00;
      if (bus.done != 2'b00) begin
        check("rereq.done_src", 32'(bus.done), 1);
        if (nd == 0) check("rereq.first_done_cycle", k, lat);
        else if (nd == 1) check("rereq.second_done_cycle", k, 2 * lat);
        nd++;
      end
    end
    bus.req = 2'b00;
    check("rereq.frame_count", nd, 2);

    // Reset after the second byte of a 5-byte frame.
    nf = 0;
    @(negedge clk);
    bus.len0 = 8'd5; bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    for (int k = 1; k <= 3 * GAP && nf < 2; k++) begin
      @(negedge clk);
      if (bus.tx_flag) nf++;
    end
    check("rst.second_byte_seen", nf, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst.tx_flag", 32'(bus.tx_flag), 0);
    check("rst.grant",   32'(bus.grant), 0);
    check("rst.busy",    32'(bus.busy), 0);
    check("rst.tx_data", 32'(bus.tx_data), 0);
    check("rst.rd_addr", 32'(bus.rd_addr), 0);
    hit = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done != 2'b00) hit = 1'b1;
    end
    check("rst.no_done", 32'(hit), 0);
    rst_n = 1'b1;
    v = '{2'b01, 8'd5, 8'd0, 5, 8'h41, 8'h45};
    run_frame(v, "after_rst");

    // "OK" frame; with TX_CRLF_EN it becomes 4F 4B 0D 0A.
    mem0[0] = 8'h4F;
    mem0[1] = 8'h4B;
    v = '{2'b01, 8'd2, 8'd0, 2, 8'h4F, 8'h4B};
    run_frame(v, "ok_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
